qa_drv_hc_tx_issue_arb: RTL

- TX request issue stage, directly downstream of the host-channel can-issue throttle.
- Arbitrates between one read-request source and one write-request source, and drives at most one request per cycle onto the host TX channels.
- Issues only while `can_issue` is high, and tags reads from a wrapping tag counter.
- Limits outstanding reads with a credit counter that read-response completions decrement.

---
 rtl/qa_drv_hc_tx_issue_arb_if.sv | 44 ++++
 rtl/qa_drv_hc_tx_issue_arb.sv | 111 +++++++++++
 2 files changed

// File: rtl/qa_drv_hc_tx_issue_arb_if.sv
// Host TX issue-stage bundle: read/write request sources, credit return, host TX channels.
// Latency: none (wiring only).
// Backpressure: rd_req_ready / wr_req_ready flow back to the request sources.
interface qa_drv_hc_tx_issue_arb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 512,
  parameter int TAG_WIDTH  = 6,
  parameter int CNT_WIDTH  = 7
);
  logic                  can_issue;
  logic                  rd_req_valid;
  logic [ADDR_WIDTH-1:0] rd_req_addr;
  logic                  rd_req_ready;
  logic                  wr_req_valid;
  logic [ADDR_WIDTH-1:0] wr_req_addr;
  logic [DATA_WIDTH-1:0] wr_req_data;
  logic                  wr_req_ready;
  logic                  rd_rsp_done;
  logic                  tx_rd_valid;
  logic [ADDR_WIDTH-1:0] tx_rd_addr;
  logic [TAG_WIDTH-1:0]  tx_rd_tag;
  logic                  tx_wr_valid;
  logic [ADDR_WIDTH-1:0] tx_wr_addr;
  logic [DATA_WIDTH-1:0] tx_wr_data;
  logic                  issue;
  logic [CNT_WIDTH-1:0]  rd_outstanding;
  logic                  credit_err;

  // Side that feeds requests and observes the host TX channels.
  modport master (
    output can_issue, rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_req_data,
           rd_rsp_done,
    input  rd_req_ready, wr_req_ready, tx_rd_valid, tx_rd_addr, tx_rd_tag, tx_wr_valid,
           tx_wr_addr, tx_wr_data, issue, rd_outstanding, credit_err
  );

  // The issue arbiter itself.
  modport slave (
    input  can_issue, rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_req_data,
           rd_rsp_done,
    output rd_req_ready, wr_req_ready, tx_rd_valid, tx_rd_addr, tx_rd_tag, tx_wr_valid,
           tx_wr_addr, tx_wr_data, issue, rd_outstanding, credit_err
  );
endinterface

// File: rtl/qa_drv_hc_tx_issue_arb.sv
// Round-robin read/write issue arbiter with read tagging and outstanding-read credit limit.
// Latency: 1 cycle from grant (valid & ready) to tx_* pulse.
// Backpressure: no grants while can_issue is low; reads also stall at MAX_RD_OUTSTANDING in flight.
module qa_drv_hc_tx_issue_arb #(
  parameter int ADDR_WIDTH         = 32,
  parameter int DATA_WIDTH         = 512,
  parameter int TAG_WIDTH          = 6,
  parameter int MAX_RD_OUTSTANDING = 32,  // must not exceed 2**TAG_WIDTH
  parameter int CNT_WIDTH          = 7    // must be able to hold MAX_RD_OUTSTANDING
) (
  input  logic                     clk,
  input  logic                     reset_n,
  qa_drv_hc_tx_issue_arb_if.slave  bus
);

  typedef enum logic {
    GRANT_RD = 1'b0,
    GRANT_WR = 1'b1
  } grant_e;

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_RD_OUTSTANDING);

  grant_e               last_grant;
  grant_e               last_grant_nxt;
  logic                 rd_elig;
  logic                 wr_elig;
  logic                 rd_grant;
  logic                 wr_grant;
  logic [TAG_WIDTH-1:0] tag_cnt;

  // Eligibility and round-robin pick; on contention the side not granted last wins.
  always_comb begin
    rd_elig        = 1'b0;
    wr_elig        = 1'b0;
    rd_grant       = 1'b0;
    wr_grant       = 1'b0;
    last_grant_nxt = last_grant;
    rd_elig  = bus.rd_req_valid & bus.can_issue & (bus.rd_outstanding < MAX_CNT);
    wr_elig  = bus.wr_req_valid & bus.can_issue;
    rd_grant = rd_elig & (~wr_elig | (last_grant == GRANT_WR));
    wr_grant = wr_elig & (~rd_elig | (last_grant == GRANT_RD));
    if (rd_grant) begin
      last_grant_nxt = GRANT_RD;
    end else if (wr_grant) begin
      last_grant_nxt = GRANT_WR;
    end
  end

  assign bus.rd_req_ready = rd_grant;
  assign bus.wr_req_ready = wr_grant;

  // Arbitration state; starts as WRITE so the first contested grant favours reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= GRANT_WR;
    end else begin
      last_grant <= last_grant_nxt;
    end
  end

  // Read channel launch: single-cycle valid, address/tag hold between grants.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.tx_rd_valid <= 1'b0;
      bus.tx_rd_addr  <= '0;
      bus.tx_rd_tag   <= '0;
      tag_cnt         <= '0;
    end else begin
      bus.tx_rd_valid <= rd_grant;
      if (rd_grant) begin
        bus.tx_rd_addr <= bus.rd_req_addr;
        bus.tx_rd_tag  <= tag_cnt;
        tag_cnt        <= tag_cnt + 1'b1;  // wraps naturally at 2**TAG_WIDTH
      end
    end
  end

  // Write channel launch and the combined issue strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.tx_wr_valid <= 1'b0;
      bus.tx_wr_addr  <= '0;
      bus.tx_wr_data  <= '0;
      bus.issue       <= 1'b0;
    end else begin
      bus.tx_wr_valid <= wr_grant;
      bus.issue       <= rd_grant | wr_grant;
      if (wr_grant) begin
        bus.tx_wr_addr <= bus.wr_req_addr;
        bus.tx_wr_data <= bus.wr_req_data;
      end
    end
  end

  // Outstanding-read credit: grant adds, completion subtracts, underflow is flagged and clamped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.rd_outstanding <= '0;
      bus.credit_err     <= 1'b0;
    end else if (rd_grant && !bus.rd_rsp_done) begin
      bus.rd_outstanding <= bus.rd_outstanding + 1'b1;
    end else if (!rd_grant && bus.rd_rsp_done) begin
      if (bus.rd_outstanding == '0) begin
        bus.credit_err <= 1'b1;
      end else begin
        bus.rd_outstanding <= bus.rd_outstanding - 1'b1;
      end
    end
  end

endmodule
